// File: rtl/ahb_cfg_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ahb_cfg_init_sequencer
// Description : Table-driven AHB-Lite master that replays a bring-up register
//               sequence from a synchronous entry ROM. Each entry is a single
//               word write or a masked read-poll with bounded retries,
//               followed by a programmable idle gap. Strictly non-pipelined:
//               one transfer is fully finished before the next is issued.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_cfg_init_sequencer #(
    parameter int IDX_W    = 6,
    parameter int GAP_W    = 16,
    parameter int POLL_MAX = 1023
) (
    input  logic              clk_80m,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              tbl_rd_en,
    output logic [IDX_W-1:0]  tbl_idx,
    input  logic              tbl_op,
    input  logic [31:0]       tbl_addr,
    input  logic [31:0]       tbl_data,
    input  logic [31:0]       tbl_mask,
    input  logic [GAP_W-1:0]  tbl_gap,
    input  logic              tbl_last,
    output logic [31:0]       proc_haddr,
    output logic [1:0]        proc_htrans,
    output logic              proc_hwrite,
    output logic [1:0]        proc_hsize,
    output logic [31:0]       proc_hwdata,
    input  logic [31:0]       proc_hrdata,
    input  logic              proc_hready,
    input  logic [1:0]        proc_hresp,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err_code,
    output logic [IDX_W-1:0]  err_idx
);

    localparam int               ATT_W        = $clog2(POLL_MAX + 1);
    localparam logic [ATT_W-1:0] c_poll_max   = ATT_W'(POLL_MAX);
    localparam logic [IDX_W-1:0] c_idx_last   = '1;
    localparam logic [1:0]       c_htrans_idl = 2'b00;
    localparam logic [1:0]       c_htrans_nsq = 2'b10;
    localparam logic [1:0]       c_hresp_err  = 2'b01;
    localparam logic [1:0]       c_err_none   = 2'b00;
    localparam logic [1:0]       c_err_bus    = 2'b01;
    localparam logic [1:0]       c_err_tmo    = 2'b10;
    localparam logic [1:0]       c_err_abort  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_ADDR  = 3'd3,
        S_DATA  = 3'd4,
        S_CHECK = 3'd5,
        S_GAP   = 3'd6,
        S_FIN   = 3'd7
    } state_t;

    state_t             state_q,    state_d;
    logic [IDX_W-1:0]   idx_q,      idx_d;
    logic               op_q,       op_d;
    logic [31:0]        addr_q,     addr_d;
    logic [31:0]        data_q,     data_d;
    logic [31:0]        mask_q,     mask_d;
    logic [GAP_W-1:0]   gap_q,      gap_d;
    logic               last_q,     last_d;
    logic [GAP_W-1:0]   gap_cnt_q,  gap_cnt_d;
    logic [ATT_W-1:0]   attempts_q, attempts_d;
    logic [31:0]        rdata_q,    rdata_d;
    logic               retry_q,    retry_d;
    logic               abort_q,    abort_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [IDX_W-1:0]   err_idx_q,  err_idx_d;

    logic               w_abort_now;
    logic               w_poll_match;
    logic [ATT_W-1:0]   w_attempts_inc;

    // An abort arriving in the same cycle as a safe point is honoured at once.
    assign w_abort_now    = abort_q | abort;
    assign w_poll_match   = (((rdata_q ^ data_q) & mask_q) == 32'h0);
    assign w_attempts_inc = attempts_q + ATT_W'(1);

    // Bus and ROM outputs decode straight from registered state.
    assign tbl_rd_en   = (state_q == S_FETCH);
    assign tbl_idx     = idx_q;
    assign proc_htrans = (state_q == S_ADDR) ? c_htrans_nsq : c_htrans_idl;
    assign proc_hwrite = (state_q == S_ADDR) & ~op_q;
    assign proc_haddr  = addr_q;
    assign proc_hwdata = data_q;
    assign proc_hsize  = 2'b10;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_code    = err_code_q;
    assign err_idx     = err_idx_q;

    // Next-state and datapath decode for the sequencer FSM.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
        mask_d     = mask_q;
        gap_d      = gap_q;
        last_d     = last_q;
        gap_cnt_d  = gap_cnt_q;
        attempts_d = attempts_q;
        rdata_d    = rdata_q;
        retry_d    = retry_q;
        abort_d    = abort_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_code_d = err_code_q;
        err_idx_d  = err_idx_q;

        // Aborts are only remembered while a sequence is running.
        if (state_q == S_IDLE) begin
            abort_d = 1'b0;
        end else if (abort) begin
            abort_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    done_d     = 1'b0;
                    err_code_d = c_err_none;
                    err_idx_d  = '0;
                    idx_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = S_FETCH;
                end
            end

            S_FETCH: begin
                if (w_abort_now) begin
                    err_code_d = c_err_abort;
                    err_idx_d  = idx_q;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_FIN;
                end else begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                if (w_abort_now) begin
                    err_code_d = c_err_abort;
                    err_idx_d  = idx_q;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_FIN;
                end else begin
                    op_d       = tbl_op;
                    addr_d     = tbl_addr;
                    data_d     = tbl_data;
                    mask_d     = tbl_mask;
                    gap_d      = tbl_gap;
                    last_d     = tbl_last;
                    attempts_d = '0;
                    retry_d    = 1'b0;
                    state_d    = S_ADDR;
                end
            end

            // Address phase is never withdrawn once presented.
            S_ADDR: begin
                if (proc_hready) begin
                    state_d = S_DATA;
                end
            end

            // Bus error wins over a pending abort on the same transfer.
            S_DATA: begin
                if (proc_hresp == c_hresp_err) begin
                    err_code_d = c_err_bus;
                    err_idx_d  = idx_q;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_FIN;
                end else if (proc_hready) begin
                    if (w_abort_now) begin
                        err_code_d = c_err_abort;
                        err_idx_d  = idx_q;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = S_FIN;
                    end else if (op_q) begin
                        rdata_d = proc_hrdata;
                        state_d = S_CHECK;
                    end else begin
                        gap_cnt_d = gap_q;
                        state_d   = S_GAP;
                    end
                end
            end

            S_CHECK: begin
                if (w_poll_match) begin
                    retry_d   = 1'b0;
                    gap_cnt_d = gap_q;
                    state_d   = S_GAP;
                end else if (w_attempts_inc == c_poll_max) begin
                    attempts_d = w_attempts_inc;
                    err_code_d = c_err_tmo;
                    err_idx_d  = idx_q;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_FIN;
                end else begin
                    attempts_d = w_attempts_inc;
                    retry_d    = 1'b1;
                    gap_cnt_d  = gap_q;
                    state_d    = S_GAP;
                end
            end

            // Gap countdown; afterwards retry the poll, advance, or finish.
            S_GAP: begin
                if (w_abort_now) begin
                    err_code_d = c_err_abort;
                    err_idx_d  = idx_q;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_FIN;
                end else if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end else if (retry_q) begin
                    retry_d = 1'b0;
                    state_d = S_ADDR;
                end else if (last_q || (idx_q == c_idx_last)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_FETCH;
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with immediate asynchronous clear.
    always_ff @(posedge clk_80m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            op_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            gap_q      <= '0;
            last_q     <= 1'b0;
            gap_cnt_q  <= '0;
            attempts_q <= '0;
            rdata_q    <= '0;
            retry_q    <= 1'b0;
            abort_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_code_q <= c_err_none;
            err_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            gap_q      <= gap_d;
            last_q     <= last_d;
            gap_cnt_q  <= gap_cnt_d;
            attempts_q <= attempts_d;
            rdata_q    <= rdata_d;
            retry_q    <= retry_d;
            abort_q    <= abort_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_code_q <= err_code_d;
            err_idx_q  <= err_idx_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_cfg_init_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ahb_cfg_init_sequencer
// Description : Directed self-checking bench: entry ROM model, AHB slave
//               model with wait states / two-cycle ERROR, and a second
//               instance with a small poll limit for the timeout case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_cfg_init_sequencer;

    localparam int IDX_W = 6;
    localparam int GAP_W = 16;

    logic clk_80m = 1'b0;
    always #5 clk_80m = ~clk_80m;

    logic rst_n, start, abort, start2, abort2;

    // ---------------- instance 1 (default poll limit) ----------------
    logic              tbl_rd_en;
    logic [IDX_W-1:0]  tbl_idx;
    logic              tbl_op   = 1'b0;
    logic [31:0]       tbl_addr = '0, tbl_data = '0, tbl_mask = '0;
    logic [GAP_W-1:0]  tbl_gap  = '0;
    logic              tbl_last = 1'b0;
    logic [31:0]       haddr, hwdata, hrdata;
    logic [1:0]        htrans, hsize, hresp, err_code;
    logic              hwrite, hready, busy, done;
    logic [IDX_W-1:0]  err_idx;

    // ---------------- instance 2 (POLL_MAX = 4) ----------------------
    logic              tbl_rd_en2;
    logic [IDX_W-1:0]  tbl_idx2;
    logic              tbl_op2   = 1'b0;
    logic [31:0]       tbl_addr2 = '0, tbl_data2 = '0, tbl_mask2 = '0;
    logic [GAP_W-1:0]  tbl_gap2  = '0;
    logic              tbl_last2 = 1'b0;
    logic [31:0]       haddr2, hwdata2;
    logic [1:0]        htrans2, hsize2, err_code2;
    logic              hwrite2, busy2, done2;
    logic [IDX_W-1:0]  err_idx2;

    ahb_cfg_init_sequencer #(.IDX_W(IDX_W), .GAP_W(GAP_W), .POLL_MAX(1023)) dut (
        .clk_80m(clk_80m), .rst_n(rst_n), .start(start), .abort(abort),
        .tbl_rd_en(tbl_rd_en), .tbl_idx(tbl_idx), .tbl_op(tbl_op),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data), .tbl_mask(tbl_mask),
        .tbl_gap(tbl_gap), .tbl_last(tbl_last),
        .proc_haddr(haddr), .proc_htrans(htrans), .proc_hwrite(hwrite),
        .proc_hsize(hsize), .proc_hwdata(hwdata), .proc_hrdata(hrdata),
        .proc_hready(hready), .proc_hresp(hresp),
        .busy(busy), .done(done), .err_code(err_code), .err_idx(err_idx)
    );

    ahb_cfg_init_sequencer #(.IDX_W(IDX_W), .GAP_W(GAP_W), .POLL_MAX(4)) dut_p4 (
        .clk_80m(clk_80m), .rst_n(rst_n), .start(start2), .abort(abort2),
        .tbl_rd_en(tbl_rd_en2), .tbl_idx(tbl_idx2), .tbl_op(tbl_op2),
        .tbl_addr(tbl_addr2), .tbl_data(tbl_data2), .tbl_mask(tbl_mask2),
        .tbl_gap(tbl_gap2), .tbl_last(tbl_last2),
        .proc_haddr(haddr2), .proc_htrans(htrans2), .proc_hwrite(hwrite2),
        .proc_hsize(hsize2), .proc_hwdata(hwdata2), .proc_hrdata(32'h0),
        .proc_hready(1'b1), .proc_hresp(2'b00),
        .busy(busy2), .done(done2), .err_code(err_code2), .err_idx(err_idx2)
    );

    // ---------------- shared entry table and ROM models --------------
    logic              t_op   [64];
    logic [31:0]       t_addr [64];
    logic [31:0]       t_data [64];
    logic [31:0]       t_mask [64];
    logic [GAP_W-1:0]  t_gap  [64];
    logic              t_last [64];

    always @(posedge clk_80m) begin
        if (tbl_rd_en) begin
            tbl_op <= t_op[tbl_idx];     tbl_addr <= t_addr[tbl_idx];
            tbl_data <= t_data[tbl_idx]; tbl_mask <= t_mask[tbl_idx];
            tbl_gap <= t_gap[tbl_idx];   tbl_last <= t_last[tbl_idx];
        end
        if (tbl_rd_en2) begin
            tbl_op2 <= t_op[tbl_idx2];     tbl_addr2 <= t_addr[tbl_idx2];
            tbl_data2 <= t_data[tbl_idx2]; tbl_mask2 <= t_mask[tbl_idx2];
            tbl_gap2 <= t_gap[tbl_idx2];   tbl_last2 <= t_last[tbl_idx2];
        end
    end

    // ---------------- AHB slave model for instance 1 -----------------
    int          ws        = 0;             // wait states per data phase
    logic [31:0] err_addr  = 32'hFFFF_FFFF; // address answered with ERROR
    int          rd_zero_n = 32'h7FFF_FFFF; // reads below this count return 0
    logic        dp = 1'b0, dp_wr = 1'b0, eph = 1'b0, prev_acc = 1'b0;
    logic [1:0]  ecnt = 2'd0;
    int          wcnt = 0;
    logic [31:0] dp_addr = '0, dp_hw = '0;
    int          wr_n = 0, rd_n = 0, ns_n = 0, rd2_n = 0, wr2_n = 0;
    int          viol_ns = 0, viol_hw = 0, viol_err = 0, err_cyc = 0;
    logic [31:0] wr_addr [256];
    logic [31:0] wr_data [256];

    assign hready = !dp ? 1'b1 : (eph ? (ecnt == 2'd1) : (wcnt == 0));
    assign hresp  = (dp && eph) ? 2'b01 : 2'b00;
    assign hrdata = (dp && !dp_wr && rd_n >= rd_zero_n) ? 32'h1 : 32'h0;

    always @(posedge clk_80m or negedge rst_n) begin
        if (!rst_n) begin
            dp <= 1'b0; eph <= 1'b0; ecnt <= 2'd0; wcnt <= 0; prev_acc <= 1'b0;
        end else begin
            if (dp) begin
                if (dp_wr && hwdata !== dp_hw) viol_hw <= viol_hw + 1;
                if (hresp == 2'b01) begin
                    err_cyc <= err_cyc + 1;
                    if (htrans !== 2'b00) viol_err <= viol_err + 1;
                end
                if (hready) begin
                    dp <= 1'b0; eph <= 1'b0; ecnt <= 2'd0;
                    if (!eph) begin
                        if (dp_wr) begin
                            wr_addr[wr_n] <= dp_addr;
                            wr_data[wr_n] <= hwdata;
                            wr_n <= wr_n + 1;
                        end else begin
                            rd_n <= rd_n + 1;
                        end
                    end
                end else if (eph) begin
                    ecnt <= ecnt + 2'd1;
                end else begin
                    wcnt <= wcnt - 1;
                end
            end
            if (htrans == 2'b10 && hready) begin
                ns_n <= ns_n + 1;
                if (prev_acc) viol_ns <= viol_ns + 1;
                prev_acc <= 1'b1;
                dp <= 1'b1; dp_wr <= hwrite; dp_addr <= haddr; dp_hw <= hwdata;
                wcnt <= ws; eph <= (haddr == err_addr); ecnt <= 2'd0;
            end else begin
                prev_acc <= 1'b0;
            end
        end
    end

    // Instance 2 slave is always ready, OKAY, read data 0.
    always @(posedge clk_80m) begin
        if (htrans2 == 2'b10) begin
            if (hwrite2) wr2_n <= wr2_n + 1;
            else         rd2_n <= rd2_n + 1;
        end
    end

    // ---------------- checking helpers --------------------------------
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ent(input int i, input logic op, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] m,
                           input logic [GAP_W-1:0] g, input logic l);
        t_op[i] = op; t_addr[i] = a; t_data[i] = d; t_mask[i] = m; t_gap[i] = g; t_last[i] = l;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk_80m);
            n++;
        end
        chk(tag, done, 1);
    endtask

    // Pulse start, then count busy cycles until done (bounded).
    task automatic run(input int budget, input string tag, output int bcyc);
        int n = 0;
        bcyc = 0;
        @(negedge clk_80m); start = 1'b1;
        @(negedge clk_80m); start = 1'b0;
        while (done !== 1'b1 && n < budget) begin
            if (busy) bcyc++;
            @(negedge clk_80m);
            n++;
        end
        chk(tag, done, 1);
    endtask

    // ---------------- directed sequence -------------------------------
    initial begin
        int bc, wb, rb, nb, eb, n;
        logic [31:0] ea [3];
        logic [31:0] ed [3];
        ea[0] = 32'h6000_0000; ea[1] = 32'h6000_0004; ea[2] = 32'h6000_0008;
        ed[0] = 32'h2000_0001; ed[1] = 32'h6000_0100; ed[2] = 32'h0000_0044;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0;
        repeat (3) @(negedge clk_80m);
        chk("rst_bus", {htrans, hwrite, hsize}, {2'b00, 1'b0, 2'b10});
        chk("rst_haddr", haddr, 0);
        chk("rst_hwdata", hwdata, 0);
        chk("rst_status", {tbl_rd_en, tbl_idx, busy, done, err_code, err_idx}, 0);
        rst_n = 1'b1;
        @(negedge clk_80m);

        // Three writes, zero gap, zero wait states.
        for (int i = 0; i < 3; i++) set_ent(i, 1'b0, ea[i], ed[i], 32'h0, '0, i == 2);
        wb = wr_n; nb = ns_n;
        run(100, "t1_done", bc);
        chk("t1_cycles", bc, 15);
        chk("t1_err", {err_code, err_idx}, 0);
        chk("t1_nonseq", ns_n - nb, 3);
        chk("t1_nwr", wr_n - wb, 3);
        for (int i = 0; i < 3; i++) begin
            chk("t1_wr", {wr_addr[wb + i], wr_data[wb + i]}, {ea[i], ed[i]});
        end

        // Same table, three wait states per data phase.
        ws = 3; wb = wr_n;
        run(150, "t2_done", bc);
        chk("t2_cycles", bc, 24);
        chk("t2_nwr", wr_n - wb, 3);
        for (int i = 0; i < 3; i++) begin
            chk("t2_wr", {wr_addr[wb + i], wr_data[wb + i]}, {ea[i], ed[i]});
        end
        chk("t2_hwdata_stable", viol_hw, 0);
        ws = 0;

        // Poll: four zero reads then a match, then the next entry runs.
        set_ent(0, 1'b1, 32'h60B0_0538, 32'h1, 32'h1, 16'd2, 1'b0);
        set_ent(1, 1'b0, 32'h6000_0010, 32'hA5, 32'h0, 16'd0, 1'b1);
        rb = rd_n; wb = wr_n; rd_zero_n = rd_n + 4;
        run(200, "t3_done", bc);
        chk("t3_reads", rd_n - rb, 5);
        chk("t3_err", err_code, 0);
        chk("t3_wr", {wr_n - wb, wr_addr[wb], wr_data[wb]}, {32'd1, 32'h6000_0010, 32'hA5});
        rd_zero_n = 32'h7FFF_FFFF;

        // Poll timeout on the POLL_MAX=4 instance.
        set_ent(0, 1'b0, 32'h6000_0020, 32'h11, 32'h0, 16'd0, 1'b0);
        set_ent(1, 1'b1, 32'h60B0_0538, 32'h1, 32'h1, 16'd1, 1'b0);
        set_ent(2, 1'b0, 32'h6000_0024, 32'h22, 32'h0, 16'd0, 1'b1);
        @(negedge clk_80m); start2 = 1'b1;
        @(negedge clk_80m); start2 = 1'b0;
        n = 0;
        while (done2 !== 1'b1 && n < 200) begin @(negedge clk_80m); n++; end
        chk("t4_done", done2, 1);
        chk("t4_reads", rd2_n, 4);
        chk("t4_writes", wr2_n, 1);
        chk("t4_err", {busy2, err_code2, err_idx2}, {1'b0, 2'b10, 6'd1});

        // Two-cycle ERROR on entry 1.
        for (int i = 0; i < 3; i++) set_ent(i, 1'b0, ea[i], ed[i], 32'h0, '0, i == 2);
        err_addr = 32'h6000_0004; wb = wr_n; eb = err_cyc;
        run(100, "t5_done", bc);
        repeat (2) @(negedge clk_80m);
        chk("t5_err", {err_code, err_idx}, {2'b01, 6'd1});
        chk("t5_nwr", wr_n - wb, 1);
        chk("t5_err_cycles", err_cyc - eb, 2);
        chk("t5_htrans_idle", viol_err, 0);
        err_addr = 32'hFFFF_FFFF;

        // Abort during a long gap after entry 0.
        set_ent(0, 1'b0, 32'h6000_0030, 32'h77, 32'h0, 16'd100, 1'b0);
        set_ent(1, 1'b0, 32'h6000_0034, 32'h78, 32'h0, 16'd0, 1'b1);
        wb = wr_n;
        @(negedge clk_80m); start = 1'b1;
        @(negedge clk_80m); start = 1'b0;
        n = 0;
        while (wr_n == wb && n < 30) begin @(negedge clk_80m); n++; end
        chk("t6_first_write", wr_n - wb, 1);
        repeat (3) @(negedge clk_80m);
        abort = 1'b1;
        @(negedge clk_80m); abort = 1'b0;
        wait_done(5, "t6_done");
        chk("t6_err", {err_code, err_idx}, {2'b11, 6'd0});
        chk("t6_nwr", wr_n - wb, 1);

        // start and abort together in IDLE: abort dropped.
        set_ent(0, 1'b0, 32'h6000_0040, 32'h99, 32'h0, 16'd0, 1'b1);
        wb = wr_n;
        @(negedge clk_80m); start = 1'b1; abort = 1'b1;
        @(negedge clk_80m); start = 1'b0; abort = 1'b0;
        wait_done(30, "t7_done");
        chk("t7_err", err_code, 0);
        chk("t7_nwr", wr_n - wb, 1);

        // Index wrap without a last flag finishes cleanly after 64 entries.
        for (int i = 0; i < 64; i++) set_ent(i, 1'b0, 32'h6100_0000 + 32'(4 * i), 32'(i), 32'h0, '0, 1'b0);
        wb = wr_n;
        run(400, "t8_done", bc);
        chk("t8_cycles", bc, 320);
        chk("t8_err", err_code, 0);
        chk("t8_nwr", wr_n - wb, 64);
        chk("t8_last_wr", {wr_addr[wb + 63], wr_data[wb + 63]}, {32'h6100_00FC, 32'd63});

        // Asynchronous reset while entry 1 is in its address phase.
        set_ent(0, 1'b0, 32'h6000_0050, 32'h5, 32'h0, 16'd0, 1'b0);
        set_ent(1, 1'b0, 32'h6000_0054, 32'h6, 32'h0, 16'd0, 1'b1);
        @(negedge clk_80m); start = 1'b1;
        @(negedge clk_80m); start = 1'b0;
        n = 0;
        while (!(tbl_idx == 6'd1 && htrans == 2'b10) && n < 30) begin @(negedge clk_80m); n++; end
        chk("t9_in_addr", {tbl_idx, htrans, busy}, {6'd1, 2'b10, 1'b1});
        #2 rst_n = 1'b0;
        #1;
        chk("t9_bus_reset", {htrans, hwrite, haddr, hwdata}, {2'b00, 1'b0, 32'h0, 32'h0});
        chk("t9_status_reset", {tbl_rd_en, tbl_idx, busy, done, err_code, err_idx}, 0);
        @(negedge clk_80m); rst_n = 1'b1;

        chk("no_back_to_back_nonseq", viol_ns, 0);
        chk("hwdata_stable_all", viol_hw, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
